// File: rtl/hazard_if.sv
// Hazard-control signal bundle between the pipeline datapath and hazard_ctrl.
interface hazard_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_ex_memread;
    logic [4:0]       id_ex_rd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_en;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_memread, id_ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en,
               mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_memread, id_ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en,
               mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, branch flushes, data-memory freeze,
// plus a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 64,
    parameter int unsigned CNT_W             = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    hazard_if.slave hz_io
);
    localparam int unsigned LU_W   = $clog2(LOAD_STALL_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

    state_e            state_q, state_d, ret_q, ret_d, eval_st;
    logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q;

    logic lu_hazard_c, mem_stall_c, freeze_c;
    logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_flush_c, pipe_en_c;

    assign lu_hazard_c = hz_io.id_ex_memread && (hz_io.id_ex_rd != 5'd0) &&
                         ((hz_io.id_uses_rs1 && (hz_io.id_rs1 == hz_io.id_ex_rd)) ||
                          (hz_io.id_uses_rs2 && (hz_io.id_rs2 == hz_io.id_ex_rd)));
    assign mem_stall_c = hz_io.mem_req && !hz_io.mem_ready;

    // Next-state and Mealy outputs; a completed memory wait re-runs the saved state's logic.
    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        lu_cnt_d      = lu_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;
        eval_st       = state_q;
        freeze_c      = 1'b0;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        pipe_en_c     = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;

        if (state_q == MEM_WAIT) begin
            eval_st    = ret_q;
            wait_cnt_d = '0;
        end

        if (state_q == MEM_WAIT && !hz_io.mem_ready) begin
            freeze_c = 1'b1;
            if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT))
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            else
                wait_cnt_d = wait_cnt_q;
        end else begin
            case (eval_st)
                RUN: begin
                    state_d = RUN;
                    if (mem_stall_c) begin
                        freeze_c   = 1'b1;
                        state_d    = MEM_WAIT;
                        ret_d      = RUN;
                        wait_cnt_d = WAIT_W'(1);
                    end else if (hz_io.ex_branch_taken) begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end else if (lu_hazard_c) begin
                        pc_write_c    = 1'b0;
                        if_id_write_c = 1'b0;
                        id_ex_flush_c = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d  = LU_STALL;
                            lu_cnt_d = LU_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                LU_STALL: begin
                    if (mem_stall_c) begin
                        freeze_c   = 1'b1;
                        state_d    = MEM_WAIT;
                        ret_d      = LU_STALL;
                        wait_cnt_d = WAIT_W'(1);
                    end else begin
                        pc_write_c    = 1'b0;
                        if_id_write_c = 1'b0;
                        id_ex_flush_c = 1'b1;
                        lu_cnt_d      = lu_cnt_q - LU_W'(1);
                        state_d       = (lu_cnt_q == LU_W'(1)) ? RUN : LU_STALL;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        if (freeze_c) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            pipe_en_c     = 1'b0;
            if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT))
                timeout_d = 1'b1;
        end

        // Reset forces a safe output set without waiting for a clock edge.
        if (!rst_n) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            pipe_en_c     = 1'b0;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            ret_q      <= RUN;
            lu_cnt_q   <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            if (!pc_write_c && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign hz_io.pc_write     = pc_write_c;
    assign hz_io.if_id_write  = if_id_write_c;
    assign hz_io.if_id_flush  = if_id_flush_c;
    assign hz_io.id_ex_flush  = id_ex_flush_c;
    assign hz_io.pipe_en      = pipe_en_c;
    assign hz_io.mem_timeout  = timeout_q;
    assign hz_io.stall_cycles = stall_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table on a single-bubble instance,
// multi-cycle sequences for timeout, reset and a three-bubble instance.
module tb_hazard_ctrl;
    localparam logic [4:0] NORM = 5'b11001;  // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en}
    localparam logic [4:0] BUB  = 5'b00011;
    localparam logic [4:0] FRZ  = 5'b00000;
    localparam logic [4:0] BRN  = 5'b11111;
    localparam logic [4:0] RSTV = 5'b00110;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    hazard_if #(.CNT_W(16)) ifa ();
    hazard_if #(.CNT_W(16)) ifb ();

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(8), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .hz_io(ifa.slave));
    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .hz_io(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, memrd, br, mreq, mrdy;
        logic [4:0] exp;
        int         exp_stall;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic u1, input logic u2, input logic memrd, input logic br,
                                input logic mreq, input logic mrdy, input logic [4:0] exp, input int st);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2; v.memrd = memrd;
        v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.exp = exp; v.exp_stall = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        ifa.id_rs1 = v.rs1; ifa.id_rs2 = v.rs2; ifa.id_ex_rd = v.rd;
        ifa.id_uses_rs1 = v.u1; ifa.id_uses_rs2 = v.u2; ifa.id_ex_memread = v.memrd;
        ifa.ex_branch_taken = v.br; ifa.mem_req = v.mreq; ifa.mem_ready = v.mrdy;
    endtask

    task automatic drive_b(input logic memrd, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic u1, input logic mreq, input logic mrdy);
        ifb.id_rs1 = rs1; ifb.id_rs2 = 5'd0; ifb.id_ex_rd = rd;
        ifb.id_uses_rs1 = u1; ifb.id_uses_rs2 = 1'b0; ifb.id_ex_memread = memrd;
        ifb.ex_branch_taken = 1'b0; ifb.mem_req = mreq; ifb.mem_ready = mrdy;
    endtask

    task automatic chk_a(input string name, input logic [4:0] exp, input logic to, input int st);
        chk({name, "_out"}, 32'({ifa.pc_write, ifa.if_id_write, ifa.if_id_flush, ifa.id_ex_flush, ifa.pipe_en}), 32'(exp));
        chk({name, "_to"}, 32'(ifa.mem_timeout), 32'(to));
        chk({name, "_stall"}, 32'(ifa.stall_cycles), 32'(st));
    endtask

    task automatic chk_b(input string name, input logic [4:0] exp, input int st);
        chk({name, "_out"}, 32'({ifb.pc_write, ifb.if_id_write, ifb.if_id_flush, ifb.id_ex_flush, ifb.pipe_en}), 32'(exp));
        chk({name, "_stall"}, 32'(ifb.stall_cycles), 32'(st));
    endtask

    // Asynchronous reset pulse placed mid-period, well clear of any rising edge.
    task automatic pulse_reset(input string name);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_a({name, "_a"}, RSTV, 1'b0, 0);
        chk_b({name, "_b"}, RSTV, 0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vec_t idle;
        n_cmp  = 0;
        n_fail = 0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);

        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
        vt[1]  = mk(5, 0, 5, 1, 0, 1, 0, 0, 0, BUB,  0);
        vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1);
        vt[3]  = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, NORM, 1);
        vt[4]  = mk(0, 7, 7, 0, 0, 1, 0, 0, 0, NORM, 1);
        vt[5]  = mk(7, 0, 7, 1, 0, 0, 0, 0, 0, NORM, 1);
        vt[6]  = mk(0, 9, 9, 0, 1, 1, 0, 0, 0, BUB,  1);
        vt[7]  = mk(5, 0, 5, 1, 0, 1, 1, 0, 0, BRN,  2);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 2);
        vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  2);
        vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  3);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  4);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, NORM, 5);
        vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 5);
        vt[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  5);
        vt[15] = mk(5, 0, 5, 1, 0, 1, 0, 1, 1, BUB,  6);
        vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 7);
        vt[17] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  7);
        vt[18] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, BRN,  8);
        vt[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 8);

        rst_n = 1'b0;
        drive_a(idle);
        drive_b(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk_a("reset_a", RSTV, 1'b0, 0);
        chk_b("reset_b", RSTV, 0);
        #1 rst_n = 1'b1;

        foreach (vt[i]) begin
            @(negedge clk);
            drive_a(vt[i]);
            #1 chk_a($sformatf("v%0d", i), vt[i].exp, 1'b0, vt[i].exp_stall);
        end

        // Long memory wait: timeout appears once the 8th wait cycle has been clocked.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            drive_a(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0));
            #1 chk_a($sformatf("to_wait%0d", k), FRZ, (k > 8), 8 + k - 1);
        end
        @(negedge clk);
        drive_a(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, NORM, 0));
        #1 chk_a("to_done", NORM, 1'b1, 20);
        @(negedge clk);
        drive_a(idle);
        #1 chk_a("to_sticky", NORM, 1'b1, 20);

        pulse_reset("to_rst");
        #1 chk_a("to_after_rst", NORM, 1'b0, 0);

        // Three-bubble load-use interrupted by a two-cycle memory freeze.
        @(negedge clk); drive_b(1, 5, 5, 1, 0, 0); #1 chk_b("lu3_c1", BUB, 0);
        @(negedge clk); drive_b(0, 0, 0, 0, 1, 0); #1 chk_b("lu3_c2", FRZ, 1);
        @(negedge clk); drive_b(0, 0, 0, 0, 1, 0); #1 chk_b("lu3_c3", FRZ, 2);
        @(negedge clk); drive_b(0, 0, 0, 0, 1, 1); #1 chk_b("lu3_c4", BUB, 3);
        @(negedge clk); drive_b(0, 0, 0, 0, 0, 0); #1 chk_b("lu3_c5", BUB, 4);
        @(negedge clk); drive_b(0, 0, 0, 0, 0, 0); #1 chk_b("lu3_c6", NORM, 5);
        @(negedge clk); #1 chk_b("lu3_c7", NORM, 5);

        // Reset in the middle of the bubble sequence abandons it.
        @(negedge clk); drive_b(1, 5, 5, 1, 0, 0); #1 chk_b("lur_c1", BUB, 5);
        @(negedge clk); drive_b(0, 0, 0, 0, 0, 0); #1 chk_b("lur_c2", BUB, 6);
        pulse_reset("lur_rst");
        #1 chk_b("lur_release", NORM, 0);
        @(negedge clk); #1 chk_b("lur_next", NORM, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage RISC-V core.
- Drives the PC, IF/ID and ID/EX write-enables and flushes, and the EX/MEM and MEM/WB enable.
- Handles three hazard sources:
  - load-use stalls with a configurable bubble count;
  - taken-branch flushes;
  - whole-pipeline freeze while data memory is not ready.
- Operand forwarding is done by the forwarding unit; this block only covers hazards that forwarding cannot resolve. It also keeps a stall performance counter.

Parameters:
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard (>=1).
- MEM_TIMEOUT, 64: MEM_WAIT cycles before mem_timeout is flagged (>=1).
- CNT_W, 16: width of the stall_cycles counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_rd  in  5  rd of the instruction in EX
- ex_branch_taken  in  1  branch/jump in EX redirects the PC
- mem_req  in  1  MEM stage has an active data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_flush  out  1  ID/EX loads a bubble (all control zero)
- pipe_en  out  1  EX/MEM and MEM/WB enable
- mem_timeout  out  1  sticky timeout flag
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
Defaults and reset:
- Default (NORMAL) output set: pc_write=1, if_id_write=1, pipe_en=1, if_id_flush=0, id_ex_flush=0.
- While rst_n=0 (asynchronous, combinational force): pc_write=0, if_id_write=0, pipe_en=0, if_id_flush=1, id_ex_flush=1.
- Reset clears state to RUN, lu_cnt=0, wait_cnt=0, ret_state=RUN, mem_timeout=0, stall_cycles=0.
- Reset mid-stall or mid-wait aborts the stall or wait immediately.

Terms:
- lu_hazard = id_ex_memread & (id_ex_rd!=0) & ((id_uses_rs1 & id_rs1==id_ex_rd) | (id_uses_rs2 & id_rs2==id_ex_rd)).
- mem_stall = mem_req & ~mem_ready.
- Outputs are Mealy: current state plus inputs. State is registered.

States RUN, LU_STALL, MEM_WAIT. Evaluation in RUN, in priority order:
1. mem_stall: freeze (pc_write=0, if_id_write=0, pipe_en=0, no flushes). Next = MEM_WAIT, ret_state<=RUN, wait_cnt<=1.
2. ex_branch_taken: NORMAL outputs plus if_id_flush=1 and id_ex_flush=1. Stay RUN. A simultaneous lu_hazard is ignored because the ID instruction is squashed.
3. lu_hazard: pc_write=0, if_id_write=0, id_ex_flush=1, pipe_en=1.
   - If LOAD_STALL_CYCLES>1: next = LU_STALL, lu_cnt<=LOAD_STALL_CYCLES-1.
   - Otherwise stay RUN.
4. Otherwise: NORMAL outputs.

LU_STALL:
- Outputs are the same as the lu_hazard set.
- mem_stall takes priority: freeze, next = MEM_WAIT, ret_state<=LU_STALL. lu_cnt is held.
- Otherwise lu_cnt decrements. When lu_cnt==1 the next state is RUN.
- ex_branch_taken cannot occur here because EX holds a bubble; it is ignored.

MEM_WAIT:
- While mem_ready=0: freeze. wait_cnt increments, saturating at MEM_TIMEOUT. When wait_cnt==MEM_TIMEOUT, mem_timeout<=1. The block keeps waiting; there is no abort.
- In the cycle mem_ready=1: outputs and next state are evaluated exactly as in ret_state with mem_stall treated as 0. wait_cnt<=0.

Flags and counter:
- mem_timeout is cleared only by reset.
- stall_cycles increments on every clock with rst_n=1 and pc_write=0, and saturates at all-ones.

Test Plan:
1. Load-use: id_ex_memread=1, id_ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle, then memread=0.
   -> that cycle: pc_write=0, if_id_write=0, id_ex_flush=1, pipe_en=1.
   -> next cycle: NORMAL.
   -> stall_cycles=1.
2. No false stalls:
   - id_ex_rd=0 with id_rs1=0 -> NORMAL.
   - id_rs2==id_ex_rd=7 with id_uses_rs2=0 -> NORMAL.
   - id_ex_memread=0 with matching rd -> NORMAL.
3. Branch beats load-use: ex_branch_taken=1 with lu_hazard=1.
   -> pc_write=1, if_id_flush=1, id_ex_flush=1.
   -> stall_cycles unchanged.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
   -> pipe_en=0 and pc_write=0 for 3 cycles; 4th cycle NORMAL.
   -> stall_cycles +3, mem_timeout=0.
5. Timeout with MEM_TIMEOUT=8: mem_ready held 0 for 12 cycles, then 1.
   -> mem_timeout rises after the 8th wait cycle and stays 1 after completion.
   -> pulsing rst_n low clears it and forces the reset output values asynchronously, without a clock edge.
6. LOAD_STALL_CYCLES=3: load-use, then mem_stall for 2 cycles during LU_STALL.
   -> total of 3 bubble cycles plus 2 freeze cycles, returning to RUN.
   -> stall_cycles=5.
   -> repeat with rst_n pulsed mid-LU_STALL: next cycle after release is NORMAL.
